// File: rtl/mag_pipe.sv
// Streaming complex-magnitude pipeline: out_mag = floor(sqrt(xh^2 + yh^2)), latency KEEP_W+2.
// Optional output peak tracker enabled by defining MAG_PEAK_EN.
module mag_pipe #(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned KEEP_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_x,
  input  logic [IN_W-1:0]   in_y,
  input  logic              in_first,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [KEEP_W-1:0] out_mag,
  output logic              out_first,
  output logic [TAG_W-1:0]  out_tag
`ifdef MAG_PEAK_EN
  ,
  output logic              peak_valid,
  output logic [KEEP_W-1:0] peak_mag,
  output logic [IDX_W-1:0]  peak_idx
`endif
);

  localparam int unsigned SQ_W  = 2 * KEEP_W;
  localparam int unsigned REM_W = KEEP_W + 2;
  localparam int unsigned NS    = KEEP_W;

  logic signed [SQ_W-1:0] x_ext;
  logic signed [SQ_W-1:0] y_ext;

  // stage 1: squares
  logic              v1_q, v1_d;
  logic [SQ_W-1:0]   sqx_q, sqx_d;
  logic [SQ_W-1:0]   sqy_q, sqy_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;
  logic              first1_q, first1_d;

  // stage 2: sum of squares
  logic              v2_q, v2_d;
  logic [SQ_W-1:0]   sum_q, sum_d;
  logic [TAG_W-1:0]  tag2_q, tag2_d;
  logic              first2_q, first2_d;

  // sqrt stages, one root bit each
  logic              vs_q     [NS];
  logic              vs_d     [NS];
  logic [KEEP_W-1:0] root_q   [NS];
  logic [KEEP_W-1:0] root_d   [NS];
  logic [TAG_W-1:0]  tags_q   [NS];
  logic [TAG_W-1:0]  tags_d   [NS];
  logic              firsts_q [NS];
  logic              firsts_d [NS];
  logic [SQ_W-1:0]   rad_q    [NS-1];
  logic [SQ_W-1:0]   rad_d    [NS-1];
  logic [REM_W-1:0]  rem_q    [NS-1];
  logic [REM_W-1:0]  rem_d    [NS-1];

  logic              src_v     [NS];
  logic [SQ_W-1:0]   src_rad   [NS];
  logic [REM_W-1:0]  src_rem   [NS];
  logic [KEEP_W-1:0] src_root  [NS];
  logic [TAG_W-1:0]  src_tag   [NS];
  logic              src_first [NS];
  logic [REM_W-1:0]  cur_rem   [NS];
  logic [REM_W-1:0]  trial     [NS];
  logic [REM_W-1:0]  nxt_rem   [NS];
  logic              ge        [NS];

  logic              out_valid_q, out_valid_d;
  logic [KEEP_W-1:0] out_mag_q, out_mag_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_first_q, out_first_d;

  assign x_ext = {{KEEP_W{in_x[IN_W-1]}}, in_x[IN_W-1 -: KEEP_W]};
  assign y_ext = {{KEEP_W{in_y[IN_W-1]}}, in_y[IN_W-1 -: KEEP_W]};

  generate
    if (IN_W > KEEP_W) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^{in_x[IN_W-KEEP_W-1:0], in_y[IN_W-KEEP_W-1:0]};
    end
  endgenerate

  // next-state for the whole datapath; data regs load only behind a set valid
  always_comb begin
    v1_d        = in_valid;
    sqx_d       = sqx_q;
    sqy_d       = sqy_q;
    tag1_d      = tag1_q;
    first1_d    = first1_q;
    v2_d        = v1_q;
    sum_d       = sum_q;
    tag2_d      = tag2_q;
    first2_d    = first2_q;
    out_valid_d = vs_q[NS-1];
    out_mag_d   = out_mag_q;
    out_tag_d   = out_tag_q;
    out_first_d = out_first_q;
    for (int j = 0; j < int'(NS); j++) begin
      vs_d[j]     = vs_q[j];
      root_d[j]   = root_q[j];
      tags_d[j]   = tags_q[j];
      firsts_d[j] = firsts_q[j];
    end
    for (int j = 0; j < int'(NS) - 1; j++) begin
      rad_d[j] = rad_q[j];
      rem_d[j] = rem_q[j];
    end

    if (in_valid) begin
      sqx_d    = x_ext * x_ext;
      sqy_d    = y_ext * y_ext;
      tag1_d   = in_tag;
      first1_d = in_first;
    end

    if (v1_q) begin
      sum_d    = sqx_q + sqy_q;
      tag2_d   = tag1_q;
      first2_d = first1_q;
    end

    src_v[0]     = v2_q;
    src_rad[0]   = sum_q;
    src_rem[0]   = '0;
    src_root[0]  = '0;
    src_tag[0]   = tag2_q;
    src_first[0] = first2_q;
    for (int j = 1; j < int'(NS); j++) begin
      src_v[j]     = vs_q[j-1];
      src_rad[j]   = rad_q[j-1];
      src_rem[j]   = rem_q[j-1];
      src_root[j]  = root_q[j-1];
      src_tag[j]   = tags_q[j-1];
      src_first[j] = firsts_q[j-1];
    end

    // digit-by-digit sqrt: bring down two radicand bits, try subtracting 4*root+1
    for (int j = 0; j < int'(NS); j++) begin
      cur_rem[j] = REM_W'({src_rem[j], src_rad[j][SQ_W-1 -: 2]});
      trial[j]   = {src_root[j], 2'b01};
      ge[j]      = (cur_rem[j] >= trial[j]);
      nxt_rem[j] = ge[j] ? (cur_rem[j] - trial[j]) : cur_rem[j];
      vs_d[j]    = src_v[j];
      if (src_v[j]) begin
        root_d[j]   = KEEP_W'({src_root[j], ge[j]});
        tags_d[j]   = src_tag[j];
        firsts_d[j] = src_first[j];
      end
    end
    for (int j = 0; j < int'(NS) - 1; j++) begin
      if (src_v[j]) begin
        rad_d[j] = src_rad[j] << 2;
        rem_d[j] = nxt_rem[j];
      end
    end

    if (vs_q[NS-1]) begin
      out_mag_d   = root_q[NS-1];
      out_tag_d   = tags_q[NS-1];
      out_first_d = firsts_q[NS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      sqx_q       <= '0;
      sqy_q       <= '0;
      tag1_q      <= '0;
      first1_q    <= 1'b0;
      v2_q        <= 1'b0;
      sum_q       <= '0;
      tag2_q      <= '0;
      first2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_tag_q   <= '0;
      out_first_q <= 1'b0;
      for (int j = 0; j < int'(NS); j++) begin
        vs_q[j]     <= 1'b0;
        root_q[j]   <= '0;
        tags_q[j]   <= '0;
        firsts_q[j] <= 1'b0;
      end
      for (int j = 0; j < int'(NS) - 1; j++) begin
        rad_q[j] <= '0;
        rem_q[j] <= '0;
      end
    end else begin
      v1_q        <= v1_d;
      sqx_q       <= sqx_d;
      sqy_q       <= sqy_d;
      tag1_q      <= tag1_d;
      first1_q    <= first1_d;
      v2_q        <= v2_d;
      sum_q       <= sum_d;
      tag2_q      <= tag2_d;
      first2_q    <= first2_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_tag_q   <= out_tag_d;
      out_first_q <= out_first_d;
      for (int j = 0; j < int'(NS); j++) begin
        vs_q[j]     <= vs_d[j];
        root_q[j]   <= root_d[j];
        tags_q[j]   <= tags_d[j];
        firsts_q[j] <= firsts_d[j];
      end
      for (int j = 0; j < int'(NS) - 1; j++) begin
        rad_q[j] <= rad_d[j];
        rem_q[j] <= rem_d[j];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_tag   = out_tag_q;
  assign out_first = out_first_q;

`ifdef MAG_PEAK_EN
  logic              peak_valid_q, peak_valid_d;
  logic [KEEP_W-1:0] peak_mag_q, peak_mag_d;
  logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;
  logic              open_q, open_d;
  logic [KEEP_W-1:0] cur_max_q, cur_max_d;
  logic [IDX_W-1:0]  cur_max_idx_q, cur_max_idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  cnt_nxt;

  // frame peak tracker; a new first publishes the frame it closes
  always_comb begin
    peak_valid_d  = 1'b0;
    peak_mag_d    = peak_mag_q;
    peak_idx_d    = peak_idx_q;
    open_d        = open_q;
    cur_max_d     = cur_max_q;
    cur_max_idx_d = cur_max_idx_q;
    cnt_d         = cnt_q;
    cnt_nxt       = (cnt_q == {IDX_W{1'b1}}) ? cnt_q : (cnt_q + IDX_W'(1));
    if (out_valid_q && out_first_q) begin
      if (open_q) begin
        peak_valid_d = 1'b1;
        peak_mag_d   = cur_max_q;
        peak_idx_d   = cur_max_idx_q;
      end
      open_d        = 1'b1;
      cnt_d         = '0;
      cur_max_d     = out_mag_q;
      cur_max_idx_d = '0;
    end else if (out_valid_q && open_q) begin
      cnt_d = cnt_nxt;
      if (out_mag_q > cur_max_q) begin
        cur_max_d     = out_mag_q;
        cur_max_idx_d = cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_valid_q  <= 1'b0;
      peak_mag_q    <= '0;
      peak_idx_q    <= '0;
      open_q        <= 1'b0;
      cur_max_q     <= '0;
      cur_max_idx_q <= '0;
      cnt_q         <= '0;
    end else begin
      peak_valid_q  <= peak_valid_d;
      peak_mag_q    <= peak_mag_d;
      peak_idx_q    <= peak_idx_d;
      open_q        <= open_d;
      cur_max_q     <= cur_max_d;
      cur_max_idx_q <= cur_max_idx_d;
      cnt_q         <= cnt_d;
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_mag   = peak_mag_q;
  assign peak_idx   = peak_idx_q;
`else
  localparam int unsigned unused_idx_w = IDX_W;
`endif

endmodule

// File: tb/tb_mag_pipe.sv
// Directed self-checking bench for mag_pipe (default KEEP_W=32, IN_W=64 build).
module tb_mag_pipe;

  localparam int unsigned IN_W   = 64;
  localparam int unsigned KEEP_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned IDX_W  = 16;
  localparam int          LAT    = 34;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [IN_W-1:0]   in_x;
  logic [IN_W-1:0]   in_y;
  logic              in_first;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic [KEEP_W-1:0] out_mag;
  logic              out_first;
  logic [TAG_W-1:0]  out_tag;
`ifdef MAG_PEAK_EN
  logic              peak_valid;
  logic [KEEP_W-1:0] peak_mag;
  logic [IDX_W-1:0]  peak_idx;
`endif

  mag_pipe #(.IN_W(IN_W), .KEEP_W(KEEP_W), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_first(in_first), .in_tag(in_tag), .out_valid(out_valid), .out_mag(out_mag),
    .out_first(out_first), .out_tag(out_tag)
`ifdef MAG_PEAK_EN
    , .peak_valid(peak_valid), .peak_mag(peak_mag), .peak_idx(peak_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] xh;
    logic [31:0] yh;
    logic [3:0]  tag;
    logic        first;
    logic [31:0] mag;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // independent reference: greedy bit search using full multiplies
  function automatic logic [31:0] ref_mag(input logic [31:0] xh, input logic [31:0] yh);
    longint      sx, sy;
    logic [63:0] s, r, t;
    sx = longint'($signed(xh));
    sy = longint'($signed(yh));
    s  = unsigned'(sx * sx) + unsigned'(sy * sy);
    r  = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= s) r = t;
    end
    return r[31:0];
  endfunction

  function automatic void add_vec(input logic v, input logic [31:0] xh, input logic [31:0] yh,
                                  input logic [3:0] tag, input logic first, input logic [31:0] mag);
    vec_t e;
    e.v = v; e.xh = xh; e.yh = yh; e.tag = tag; e.first = first; e.mag = mag;
    vq.push_back(e);
  endfunction

  task automatic drive_vec(input vec_t e);
    in_valid = e.v;
    in_x     = {e.xh, 32'($urandom())};
    in_y     = {e.yh, 32'($urandom())};
    in_tag   = e.tag;
    in_first = e.first;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_x     = {32'($urandom()), 32'($urandom())};
    in_y     = {32'($urandom()), 32'($urandom())};
    in_tag   = 4'($urandom());
    in_first = 1'($urandom());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_mag !== '0 || out_tag !== '0 || out_first !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b mag=%h tag=%h first=%b, required all zero",
               out_valid, out_mag, out_tag, out_first);
    end
`ifdef MAG_PEAK_EN
    n_checks++;
    if (peak_valid !== 1'b0 || peak_mag !== '0 || peak_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_peak: pv=%b mag=%h idx=%h, required all zero", peak_valid, peak_mag, peak_idx);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int n;
    vq.delete();
    add_vec(1, 32'd3,          32'd4,          4'd5,  1, 32'd5);
    add_vec(1, 32'h8000_0000,  32'h8000_0000,  4'd1,  0, 32'hB504_F333);
    add_vec(0, 32'd0,          32'd0,          4'd0,  0, 32'd0);
    add_vec(1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd2,  0, 32'd1);
    add_vec(1, 32'd0,          32'd0,          4'd3,  0, 32'd0);
    add_vec(1, 32'h7FFF_FFFF,  32'd0,          4'd4,  0, 32'h7FFF_FFFF);
    add_vec(1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  4'd6,  1, 32'hB504_F332);
    add_vec(1, 32'hFFFF_FFFD,  32'd4,          4'd7,  0, 32'd5);
    add_vec(1, 32'h8000_0000,  32'd0,          4'd8,  0, 32'h8000_0000);
    add_vec(1, 32'd12,         32'd5,          4'd15, 1, 32'd13);
    n = vq.size();
    for (int i = 0; i <= n + LAT + 1; i++) begin
      @(negedge clk);
      if (i >= LAT + 1 && i - (LAT + 1) < n) begin
        vec_t e;
        e = vq[i - (LAT + 1)];
        n_checks++;
        if (out_valid !== e.v) begin
          n_fail++;
          $display("FAIL dir_valid[%0d]: got %b required %b", i - (LAT + 1), out_valid, e.v);
        end else if (e.v) begin
          n_checks++;
          if (out_mag !== e.mag) begin
            n_fail++;
            $display("FAIL dir_mag[%0d]: got %h required %h", i - (LAT + 1), out_mag, e.mag);
          end
          n_checks++;
          if (out_tag !== e.tag || out_first !== e.first) begin
            n_fail++;
            $display("FAIL dir_side[%0d]: tag/first got %h/%b required %h/%b",
                     i - (LAT + 1), out_tag, out_first, e.tag, e.first);
          end
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL dir_idle[%0d]: out_valid got %b required 0", i, out_valid);
        end
      end
      if (i < n) drive_vec(vq[i]); else drive_idle();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    vq.delete();
    for (int k = 0; k < 300; k++) begin
      logic [31:0] xh, yh;
      logic        v;
      xh = $urandom();
      yh = $urandom();
      v  = ($urandom_range(0, 3) != 0);
      add_vec(v, xh, yh, 4'($urandom()), 1'($urandom()), ref_mag(xh, yh));
    end
    n = vq.size();
    for (int i = 0; i <= n + LAT + 1; i++) begin
      @(negedge clk);
      if (i >= LAT + 1 && i - (LAT + 1) < n) begin
        vec_t e;
        e = vq[i - (LAT + 1)];
        n_checks++;
        if (out_valid !== e.v) begin
          n_fail++;
          $display("FAIL b2b_valid[%0d]: got %b required %b", i - (LAT + 1), out_valid, e.v);
        end else if (e.v) begin
          n_checks++;
          if (out_mag !== e.mag || out_tag !== e.tag || out_first !== e.first) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: mag/tag/first got %h/%h/%b required %h/%h/%b",
                     i - (LAT + 1), out_mag, out_tag, out_first, e.mag, e.tag, e.first);
          end
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle[%0d]: out_valid got %b required 0", i, out_valid);
        end
      end
      if (i < n) drive_vec(vq[i]); else drive_idle();
    end
  endtask

  task automatic test_reset_mid();
    vec_t e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_pre[%0d]: out_valid got %b required 0", i, out_valid);
      end
      e.v = 1'b1; e.xh = $urandom(); e.yh = $urandom(); e.tag = 4'($urandom()); e.first = 1'b1;
      drive_vec(e);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_mag !== '0 || out_tag !== '0 || out_first !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b mag=%h tag=%h first=%b, required all zero",
               out_valid, out_mag, out_tag, out_first);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= LAT + 25; i++) begin
      @(negedge clk);
      n_checks++;
      if (i == LAT + 1) begin
        if (out_valid !== 1'b1 || out_mag !== 32'd5 || out_tag !== 4'd9) begin
          n_fail++;
          $display("FAIL rstmid_next: valid/mag/tag got %b/%h/%h required 1/5/9", out_valid, out_mag, out_tag);
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_flush[%0d]: out_valid got %b required 0", i, out_valid);
      end
      if (i == 0) begin
        e.v = 1'b1; e.xh = 32'd3; e.yh = 32'd4; e.tag = 4'd9; e.first = 1'b0;
        drive_vec(e);
      end else begin
        drive_idle();
      end
    end
  endtask

`ifdef MAG_PEAK_EN
  task automatic test_peak();
    int n, pulses;
    int pulse_at;
    vq.delete();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    add_vec(1, 32'd20, 32'd0, 4'd0, 0, 32'd20);
    add_vec(1, 32'd7,  32'd0, 4'd0, 0, 32'd7);
    add_vec(1, 32'd2,  32'd0, 4'd1, 1, 32'd2);
    add_vec(1, 32'd9,  32'd0, 4'd1, 0, 32'd9);
    add_vec(1, 32'd4,  32'd0, 4'd1, 0, 32'd4);
    add_vec(1, 32'd9,  32'd0, 4'd1, 0, 32'd9);
    add_vec(1, 32'd1,  32'd0, 4'd2, 1, 32'd1);
    add_vec(1, 32'd3,  32'd0, 4'd2, 0, 32'd3);
    n        = vq.size();
    pulses   = 0;
    pulse_at = 6 + LAT + 2;
    for (int i = 0; i <= n + LAT + 4; i++) begin
      @(negedge clk);
      if (peak_valid === 1'b1) pulses++;
      n_checks++;
      if (peak_valid !== (i == pulse_at)) begin
        n_fail++;
        $display("FAIL peak_pulse[%0d]: peak_valid got %b required %b", i, peak_valid, (i == pulse_at));
      end
      if (i == pulse_at) begin
        n_checks++;
        if (peak_mag !== 32'd9 || peak_idx !== 16'd1) begin
          n_fail++;
          $display("FAIL peak_value: mag/idx got %h/%h required 9/1", peak_mag, peak_idx);
        end
      end
      if (i < n) drive_vec(vq[i]); else drive_idle();
    end
    n_checks++;
    if (pulses != 1 || peak_mag !== 32'd9 || peak_idx !== 16'd1) begin
      n_fail++;
      $display("FAIL peak_hold: pulses/mag/idx got %0d/%h/%h required 1/9/1", pulses, peak_mag, peak_idx);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
`ifdef MAG_PEAK_EN
    test_peak();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
